// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - priority interrupt controller with pending/mask/status bus registers
// Optional macro INTC_IRQ_SYNC_EN adds a two-flop synchronizer on irq_in.
module interrupt_controller #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter logic [6:0]  RESET_MASK = 7'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  irq_in,
    input  logic [15:0] bus_address,
    input  logic [15:0] bus_wdata,
    input  logic        bus_read_en,
    input  logic        bus_write_en,
    output logic [15:0] bus_rdata,
    output logic        bus_hit,
    output logic        interrupt_en,
    output logic [2:0]  interrupt_num,
    input  logic        interrupt_ack
);

    typedef enum logic [1:0] {IDLE, SERVICE, RELEASE} state_t;

    state_t      state, state_next;
    logic [6:0]  pending, mask, irq_prev, irq_src, irq_edge, req, w1c, grant_clr;
    logic        ack_prev, en_next;
    logic [2:0]  num_next, winner;
    logic [15:0] offset;
    logic        in_block, mask_wr;
    logic        wdata_unused;

`ifdef INTC_IRQ_SYNC_EN
    logic [6:0] irq_meta, irq_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= irq_in;
            irq_sync <= irq_meta;
        end
    end

    assign irq_src = irq_sync;
`else
    assign irq_src = irq_in;
`endif

    assign irq_edge     = irq_src & ~irq_prev;
    assign offset       = bus_address - BASE_ADDR;
    assign in_block     = offset < 16'd3;
    assign req          = pending & mask;
    assign w1c          = (bus_write_en && in_block && offset[1:0] == 2'd0) ? bus_wdata[6:0] : 7'd0;
    assign mask_wr      = bus_write_en && in_block && offset[1:0] == 2'd1;
    assign wdata_unused = &{1'b0, bus_wdata[15:7]};

    // Scan downward so the lowest requesting line ends up as the winner.
    always_comb begin
        winner = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (req[i]) winner = 3'(i + 1);
        end
    end

    always_comb begin
        state_next = state;
        en_next    = interrupt_en;
        num_next   = interrupt_num;
        grant_clr  = 7'd0;
        case (state)
            IDLE: begin
                if (req != 7'd0) begin
                    state_next = SERVICE;
                    en_next    = 1'b1;
                    num_next   = winner;
                    grant_clr  = 7'd1 << (winner - 3'd1);
                end
            end
            SERVICE: begin
                if (interrupt_ack && !ack_prev) begin
                    state_next = RELEASE;
                    en_next    = 1'b0;
                end
            end
            RELEASE: begin
                if (!interrupt_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            interrupt_en  <= 1'b0;
            interrupt_num <= 3'd0;
            ack_prev      <= 1'b0;
            irq_prev      <= 7'd0;
            pending       <= 7'd0;
            mask          <= RESET_MASK;
        end else begin
            state         <= state_next;
            interrupt_en  <= en_next;
            interrupt_num <= num_next;
            ack_prev      <= interrupt_ack;
            irq_prev      <= irq_src;
            // A fresh edge outranks both W1C and the grant clear.
            pending       <= (pending & ~(w1c | grant_clr)) | irq_edge;
            if (mask_wr) mask <= bus_wdata[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rdata <= 16'd0;
            bus_hit   <= 1'b0;
        end else if (bus_read_en && in_block) begin
            bus_hit <= 1'b1;
            case (offset[1:0])
                2'd0:    bus_rdata <= {9'd0, pending};
                2'd1:    bus_rdata <= {9'd0, mask};
                default: bus_rdata <= {12'd0, interrupt_num, state == SERVICE};
            endcase
        end else begin
            bus_rdata <= 16'd0;
            bus_hit   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized bench for interrupt_controller against a reference model
module tb_interrupt_controller;

    localparam logic [15:0] BASE = 16'hFF00;
`ifdef INTC_IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  irq_in;
    logic [15:0] bus_address, bus_wdata, bus_rdata;
    logic        bus_read_en, bus_write_en, bus_hit;
    logic        interrupt_en, interrupt_ack;
    logic [2:0]  interrupt_num;

    interrupt_controller dut (
        .clk(clk), .rst(rst), .irq_in(irq_in),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_read_en(bus_read_en), .bus_write_en(bus_write_en),
        .bus_rdata(bus_rdata), .bus_hit(bus_hit),
        .interrupt_en(interrupt_en), .interrupt_num(interrupt_num),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 in service, 2 waiting for ack release.
    logic [6:0]  m_pend, m_mask, m_prev, m_s1, m_s2;
    logic [2:0]  m_num;
    int          m_phase;
    bit          m_en, m_ackp, m_hit;
    logic [15:0] m_rd;

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
        m_num = 0; m_phase = 0; m_en = 0; m_ackp = 0; m_hit = 0; m_rd = 0;
    endtask

    task automatic model_step();
        logic [6:0] src, edges, clr, req, new_mask;
        int off, win;
`ifdef INTC_IRQ_SYNC_EN
        src  = m_s2;
        m_s2 = m_s1;
        m_s1 = irq_in;
`else
        src = irq_in;
`endif
        edges  = src & ~m_prev;
        m_prev = src;
        off    = int'(bus_address) - int'(BASE);
        if (bus_read_en && off >= 0 && off <= 2) begin
            m_hit = 1;
            if (off == 0)      m_rd = {9'd0, m_pend};
            else if (off == 1) m_rd = {9'd0, m_mask};
            else               m_rd = {12'd0, m_num, m_phase == 1};
        end else begin
            m_hit = 0;
            m_rd  = 0;
        end
        clr      = 0;
        new_mask = m_mask;
        if (bus_write_en && off == 0) clr = bus_wdata[6:0];
        if (bus_write_en && off == 1) new_mask = bus_wdata[6:0];
        req = m_pend & m_mask;
        if (m_phase == 0 && req != 0) begin
            win = 0;
            for (int i = 0; i < 7; i++) if (req[i]) begin win = i; break; end
            m_num   = 3'(win + 1);
            clr     = clr | 7'(1 << win);
            m_en    = 1;
            m_phase = 1;
        end else if (m_phase == 1 && interrupt_ack && !m_ackp) begin
            m_en    = 0;
            m_phase = 2;
        end else if (m_phase == 2 && !interrupt_ack) begin
            m_phase = 0;
        end
        m_ackp = interrupt_ack;
        m_pend = (m_pend & ~clr) | edges;
        m_mask = new_mask;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("en",    {15'd0, interrupt_en}, {15'd0, m_en});
        check("num",   {13'd0, interrupt_num}, {13'd0, m_num});
        check("rdata", bus_rdata, m_rd);
        check("hit",   {15'd0, bus_hit}, {15'd0, m_hit});
    endtask

    task automatic bus_set(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        bus_read_en = rd; bus_write_en = wr; bus_address = a; bus_wdata = d;
    endtask

    int  ack_hold;
    bit  did_rst;

    initial begin
        rst = 1'b0; irq_in = 0; interrupt_ack = 0;
        bus_set(0, 0, 16'h0000, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",    {15'd0, interrupt_en}, 16'd0);
        check("rst_num",   {13'd0, interrupt_num}, 16'd0);
        check("rst_rdata", bus_rdata, 16'd0);
        check("rst_hit",   {15'd0, bus_hit}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        bus_set(0, 1, BASE + 16'd1, 16'h007F); tick();
        bus_set(0, 0, 16'h0000, 16'h0000);
        irq_in = 7'b0000100; tick();
        irq_in = 7'b0000000;
        for (int i = 1; i < LAT; i++) tick();
        check("line3_en",  {15'd0, interrupt_en}, 16'd1);
        check("line3_num", {13'd0, interrupt_num}, 16'd3);
        bus_set(1, 0, BASE + 16'd2, 16'h0000); tick();
        check("status_svc", bus_rdata, 16'h0007);
        bus_set(1, 0, BASE, 16'h0000); tick();
        check("pend_after_grant", bus_rdata, 16'h0000);
        bus_set(0, 0, 16'h0000, 16'h0000);
        interrupt_ack = 1; tick(); tick();
        interrupt_ack = 0; tick(); tick();

        bus_set(0, 1, BASE + 16'd1, 16'h0000); tick();
        irq_in = 7'b0000001;
        bus_set(0, 1, BASE, 16'h0001); tick();
        irq_in = 7'b0000000;
        bus_set(1, 0, BASE, 16'h0000); repeat (LAT) tick();
        check("w1c_set_wins", bus_rdata, 16'h0001);
        bus_set(0, 1, BASE, 16'h0001); tick();
        bus_set(1, 0, BASE, 16'h0000); tick();
        check("w1c_clear", bus_rdata, 16'h0000);
        bus_set(1, 0, 16'h1234, 16'h0000); tick();
        check("miss_hit", {15'd0, bus_hit}, 16'd0);

        ack_hold = 0;
        did_rst  = 0;
        for (int n = 0; n < 4000; n++) begin
            int a, r;
            for (int b = 0; b < 7; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            a = $urandom_range(0, 5);
            case (a)
                0, 1, 2: bus_address = BASE + 16'(a);
                3:       bus_address = BASE - 16'd1;
                4:       bus_address = BASE + 16'd3;
                default: bus_address = 16'($urandom);
            endcase
            r = $urandom_range(0, 9);
            bus_read_en  = (r < 4) || (r == 5);
            bus_write_en = (r == 4) || (r == 5);
            bus_wdata    = 16'($urandom);
            if (bus_address == BASE + 16'd1 && $urandom_range(0, 3) != 0) bus_wdata = 16'h007F;
            if (ack_hold > 0) begin
                interrupt_ack = 1; ack_hold--;
            end else if (m_en && $urandom_range(0, 3) == 0) begin
                interrupt_ack = 1; ack_hold = $urandom_range(0, 4);
            end else begin
                interrupt_ack = ($urandom_range(0, 15) == 0);
            end
            tick();

            if (n >= 2000 && !did_rst && m_phase == 1) begin
                did_rst = 1;
                #1 rst = 1'b0;
                #1;
                check("async_rst_en",  {15'd0, interrupt_en}, 16'd0);
                check("async_rst_num", {13'd0, interrupt_num}, 16'd0);
                model_reset();
                irq_in = 0; interrupt_ack = 0; ack_hold = 0;
                bus_set(0, 0, 16'h0000, 16'h0000);
                @(negedge clk);
                rst = 1'b1;
                bus_set(1, 0, BASE + 16'd1, 16'h0000); tick();
                check("rst_mask", bus_rdata, 16'h0000);
                bus_set(1, 0, BASE, 16'h0000); tick();
                check("rst_pend", bus_rdata, 16'h0000);
            end
        end
        check("rst_done", {15'd0, did_rst}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Responder-side interrupt source for the CPU control unit.
- Latches peripheral interrupt edges and arbitrates them by priority. Drives interrupt_en/interrupt_num toward the CPU and retires the in-service request on the CPU's interrupt_ack.
- Exposes pending/mask/status registers as a memory-mapped responder on the CPU RAM bus.
- The CPU vectors to 0x0100 - interrupt_num, so number 0 (the reset vector) is never issued; lines 1..7 only.

Parameters:
- BASE_ADDR, 16'hFF00, word address of register block (3 consecutive words).
- RESET_MASK, 7'h00, reset value of MASK register (bit i-1 enables line i).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- irq_in  input  7  peripheral request lines; bit i-1 = interrupt i; rising edge sets pending
- bus_address  input  16  CPU ram_address_in
- bus_wdata  input  16  CPU ram_data_out
- bus_read_en  input  1  CPU ram_read_en
- bus_write_en  input  1  CPU ram_write_en
- bus_rdata  output  16  register read data; 0 when not addressed (OR-combined with RAM data)
- bus_hit  output  1  registered: previous cycle's read addressed this block
- interrupt_en  output  1  request to CPU
- interrupt_num  output  3  granted interrupt number, 1..7
- interrupt_ack  input  1  CPU end-of-service; level, may stay high several cycles

Behaviour:
- Reset (rst=0, async): pending=0, mask=RESET_MASK, irq_prev=0, state=IDLE, interrupt_en=0, interrupt_num=0, bus_rdata=0, bus_hit=0, ack_prev=0.
- Edge detect: irq_prev <= irq_in each cycle; pending[i] set when irq_in[i]&~irq_prev[i]. Level held high sets pending once.
- Registers (offset from BASE_ADDR):
  - +0 PENDING: read [6:0]. Write is W1C on [6:0].
  - +1 MASK: read/write [6:0].
  - +2 STATUS: read bit0=in_service, bits[3:1]=interrupt_num. Writes ignored.
  - Upper bits read 0. Other offsets are not decoded.
- Read latency: bus_rdata and bus_hit register on the cycle bus_read_en && address hit; valid the following cycle. Otherwise bus_rdata=0 and bus_hit=0 the following cycle.
- Write takes effect the cycle after bus_write_en. Read and write in the same cycle: write has priority and the read returns the old value.
- Same-cycle new edge and W1C on the same bit: set wins.
- Request vector: req = pending & mask. Lowest set index has highest priority, so line 1 beats line 7.
- FSM:
  - IDLE: if req!=0, latch interrupt_num=winner, clear that pending bit, interrupt_en<=1, go to SERVICE.
  - SERVICE: interrupt_en held 1 and interrupt_num held stable regardless of new edges, mask or pending writes. On ack rising edge (interrupt_ack & ~ack_prev): interrupt_en<=0, go to RELEASE.
  - RELEASE: waits until interrupt_ack=0, then goes to IDLE. Guarantees one ack retires exactly one interrupt.
- Ack in IDLE is ignored, except that ack_prev tracks it.
- Masking a line while it is in SERVICE does not revoke the grant.
- Grant-to-interrupt_en latency: 1 cycle after req becomes nonzero. Edge-to-interrupt_en: 2 cycles (edge captured into pending, then grant).
- No nesting: at most one interrupt outstanding.
- Reset asserted mid-service drops interrupt_en immediately and loses all pending state.

Optional Feature:
- INTC_IRQ_SYNC_EN defined:
  - Adds a two-flop synchronizer (reset 0) on each irq_in bit ahead of edge detection.
  - Edge-to-interrupt_en latency becomes 4 cycles.
- Undefined: irq_in is assumed synchronous to clk; latency is 2 cycles.
- All other behaviour is identical in both cases.

Test Plan:
- Reset, write MASK=7'h7F, pulse irq_in[2] (line 3) -> interrupt_en=1, interrupt_num=3 two cycles after the edge (4 with INTC_IRQ_SYNC_EN); PENDING reads 0.
- Edges on lines 5 and 2 in the same cycle -> num=2 granted first. Ack high 4 cycles -> interrupt_en drops next cycle and stays low until ack falls. Then num=5 is granted 1 cycle after RELEASE exits.
- MASK=0, pulse line 4 -> no interrupt_en; PENDING reads 16'h0008. Write MASK=16'h0008 -> interrupt_en with num=4 two cycles after the write.
- W1C PENDING=16'h0001 in the same cycle as a new edge on line 1 -> bit stays set. W1C without an edge -> reads 0.
- Read STATUS during SERVICE of num=6 -> bus_rdata=16'h000D and bus_hit=1 the next cycle. Read of a non-block address -> bus_rdata=0, bus_hit=0.
- Drive rst low mid-SERVICE -> interrupt_en=0, MASK=RESET_MASK, PENDING=0 immediately without a clock edge. Ack pulse in IDLE -> no state change.
